tile_lane_engine: RTL and testbench
===================================

# tile_lane_engine

Parametrised game core for the piano-tiles design. It holds a LANES×ROWS tile board and scrolls it down one row per game tick, inserting a new LFSR-chosen tile at the top. It judges single-cycle lane hits against the bottom row and keeps score and miss counts. It also streams a full board redraw to the VGA adapter, one pixel per cycle, through its x/y/colour/write port.

## Interface

Parameters:
- LANES, 4: lane count. Must be 2, 4 or 8; the lane index width is LB = log2(LANES).
- ROWS, 8: board rows. Row 0 is the top row and row ROWS-1 is the hit row.
- TILE_W, 40: tile width in pixels.
- TILE_H, 30: tile height in pixels.
- X0, 0: board x origin on screen.
- Y0, 0: board y origin on screen.
- TICK_DIV, 25000000: clock cycles per game tick. Must be greater than the draw length D = LANES·TILE_W·ROWS·TILE_H.
- MAX_MISS, 3: miss count that ends the game. Range 1..15.
- SEED, 8'hA5: LFSR reset value. Must be non-zero.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle pulse that starts or restarts a game. Honoured only in IDLE and OVER.
- hit, in, LANES: single-cycle, pre-debounced lane press pulses.
- vga_x, out, 10: pixel x, registered.
- vga_y, out, 9: pixel y, registered.
- vga_color, out, 3: pixel colour in {R,G,B} order, registered.
- vga_write, out, 1: pixel write strobe, registered.
- score, out, 8: hit count. Saturates at 255.
- misses, out, 4: miss count.
- game_over, out, 1: high while in OVER.
- busy, out, 1: high in every state except IDLE and OVER.

## Operation

- States: IDLE, WAIT, SHIFT, DRAW, OVER. Reset enters IDLE.
- Reset values:
  - board empty; lfsr = SEED; all counters 0.
  - vga_x, vga_y, vga_color, vga_write = 0.
  - score, misses, game_over, busy = 0.
- IDLE or OVER with start:
  - clear the board, score and misses, and the tick counter;
  - keep the current lfsr value;
  - go to DRAW.
- Tick counter:
  - runs in WAIT, SHIFT and DRAW; counts 0..TICK_DIV-1 and wraps;
  - the wrap cycle sets tick_pend.
- WAIT:
  - if tick_pend: go to SHIFT;
  - else if redraw_pend: go to DRAW.
- SHIFT (1 cycle):
  - if row ROWS-1 still holds a tile, misses += 1;
  - rows move down by one;
  - row 0 becomes one-hot at lane lfsr[LB-1:0];
  - lfsr advances one step: Fibonacci, taps 8,6,5,4, shifting left with feedback into bit 0;
  - tick_pend is cleared;
  - if misses has reached MAX_MISS, go to OVER-draw; otherwise go to DRAW.
- Hit judging, in WAIT and DRAW only. Hits in SHIFT, IDLE and OVER are ignored.
  - Exactly one bit set and it matches the tile in row ROWS-1: clear that tile, score += 1, set redraw_pend.
  - Any other non-zero hit value (no tile, wrong lane, or more than one bit set): misses += 1. This counts as one miss per pulse.
  - If misses reaches MAX_MISS, go to OVER-draw. An in-progress DRAW completes first.
- DRAW:
  - raster scan px = 0..LANES·TILE_W-1 (inner loop), py = 0..ROWS·TILE_H-1 (outer loop);
  - one pixel per cycle, vga_write = 1 for D consecutive cycles;
  - pixel cell = (px/TILE_W, py/TILE_H);
  - colour: tile = 3'b000, empty = 3'b111;
  - redraw_pend is cleared on entry;
  - on the last pixel: go to WAIT, or to OVER-draw if the miss limit has been reached.
- OVER-draw:
  - one full D-pixel pass, all pixels 3'b100;
  - then OVER with vga_write = 0.

## Timing

- Pixel outputs are registered and update together; vga_write is high in the same cycle as a valid x/y/colour.
- vga_x = X0 + px; vga_y = Y0 + py. Both are truncated to the port widths.
- Hit to score/misses update: 1 cycle.
- A tick during DRAW is held in tick_pend; SHIFT runs in the first WAIT cycle after the draw.
- A hit and a tick wrap in the same cycle are both honoured. The hit is judged against the pre-shift board.
- score saturates at 255. misses stops at MAX_MISS.
- Asynchronous reset mid-DRAW: vga_write drops immediately and all state returns to reset values.

## Test plan

Bench parameters: LANES=4, ROWS=4, TILE_W=2, TILE_H=2, TICK_DIV=200, MAX_MISS=3, giving D=64.

- Reset, then a start pulse -> exactly 64 consecutive vga_write cycles, all colour 3'b111, x in 0..7, y in 0..7; then WAIT with busy=1.
- 4 ticks -> the first tile (lane 1, from SEED bits 01) reaches row 3. After the redraw, hit=4'b0010 -> score=1, misses=0, and the next redraw shows lane 1 of row 3 white.
- With a lane-1 tile in row 3, hit=4'b0100 -> misses=1, score unchanged, tile still present.
- hit=4'b0011 -> misses increments by exactly 1.
- No hits for the rest of the game -> misses reach 3, game_over=1, one 64-pixel pass with colour 3'b100, then vga_write=0 and hits ignored. A start pulse then restarts with score=0 and misses=0.
- Assert reset during cycle 30 of a DRAW -> vga_write=0 in that same cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/tile_lane_engine_if.sv
// rtl/tile_lane_engine_if.sv - control and VGA pixel bundle for the tile lane engine
//
// Ports carried:
//   start      controller -> engine, 1-cycle game start/restart pulse
//   hit        controller -> engine, LANES single-cycle lane press pulses
//   vga_x/y    engine -> adapter, registered pixel coordinate
//   vga_color  engine -> adapter, registered {R,G,B}
//   vga_write  engine -> adapter, pixel write strobe
//   score      engine -> controller, saturating hit count
//   misses     engine -> controller, miss count
//   game_over  engine -> controller, game finished
//   busy       engine -> controller, game in progress
// master = the side driving start/hit; slave = the engine.

interface tile_lane_engine_if #(
  parameter int LANES = 4
);
  logic             start;
  logic [LANES-1:0] hit;
  logic [9:0]       vga_x;
  logic [8:0]       vga_y;
  logic [2:0]       vga_color;
  logic             vga_write;
  logic [7:0]       score;
  logic [3:0]       misses;
  logic             game_over;
  logic             busy;

  modport master (
    output start, hit,
    input  vga_x, vga_y, vga_color, vga_write, score, misses, game_over, busy
  );

  modport slave (
    input  start, hit,
    output vga_x, vga_y, vga_color, vga_write, score, misses, game_over, busy
  );
endinterface

// File: rtl/tile_lane_engine.sv
// rtl/tile_lane_engine.sv - piano-tiles board, hit judge, scroll tick and raster redraw
//
// Ports:
//   clock  system clock
//   reset  asynchronous active-high reset
//   bus    tile_lane_engine_if.slave: start/hit in; vga_x/vga_y/vga_color/vga_write,
//          score, misses, game_over, busy out
// The board is LANES x ROWS; row 0 is the top, row ROWS-1 is the hit row.

module tile_lane_engine #(
  parameter int         LANES    = 4,
  parameter int         ROWS     = 8,
  parameter int         TILE_W   = 40,
  parameter int         TILE_H   = 30,
  parameter int         X0       = 0,
  parameter int         Y0       = 0,
  parameter int         TICK_DIV = 25000000,
  parameter int         MAX_MISS = 3,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  tile_lane_engine_if.slave  bus
);

  localparam int              LB        = $clog2(LANES);
  localparam int              RB        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int              TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [9:0]      PX_LAST   = 10'(LANES * TILE_W - 1);
  localparam logic [8:0]      PY_LAST   = 9'(ROWS * TILE_H - 1);
  localparam logic [9:0]      SX_LAST   = 10'(TILE_W - 1);
  localparam logic [8:0]      SY_LAST   = 9'(TILE_H - 1);
  localparam logic [3:0]      MISS_MAX  = 4'(MAX_MISS);

  // S_ODRAW is the red end-of-game pass that precedes S_OVER.
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SHIFT, S_DRAW, S_ODRAW, S_OVER
  } state_t;

  state_t state, state_next;

  logic [ROWS-1:0][LANES-1:0] board;
  logic [7:0]                 lfsr;
  logic [TW-1:0]              tick_cnt;
  logic                       tick_pend;
  logic                       redraw_pend;
  logic [7:0]                 score_q;
  logic [3:0]                 misses_q;

  // Raster position plus the cell it falls in, tracked incrementally so no divider is needed.
  logic [9:0]    px, sx;
  logic [8:0]    py, sy;
  logic [LB-1:0] lane_c;
  logic [RB-1:0] row_c;

  logic [9:0] vga_x_q;
  logic [8:0] vga_y_q;
  logic [2:0] vga_color_q;
  logic       vga_write_q;

  logic             start_ok, hit_act, hit_single, hit_good, hit_bad;
  logic             shift_miss, miss_event, miss_limit;
  logic             scan_active, scan_last, tick_run, tick_wrap;
  logic [3:0]       misses_next;
  logic [LANES-1:0] new_row;
  logic             lfsr_fb;

  always_comb begin
    start_ok    = (state == S_IDLE || state == S_OVER) && bus.start;
    hit_act     = (state == S_WAIT || state == S_DRAW) && (bus.hit != '0);
    hit_single  = (bus.hit & (bus.hit - LANES'(1))) == '0;
    hit_good    = hit_act && hit_single && ((bus.hit & board[ROWS-1]) != '0);
    // Wrong lane, empty hit row and multi-lane presses all count as a single miss.
    hit_bad     = hit_act && !hit_good;
    shift_miss  = (state == S_SHIFT) && (board[ROWS-1] != '0);
    miss_event  = hit_bad || shift_miss;
    misses_next = (miss_event && misses_q != MISS_MAX) ? misses_q + 4'd1 : misses_q;
    miss_limit  = (misses_next == MISS_MAX);
    scan_active = (state == S_DRAW || state == S_ODRAW);
    scan_last   = scan_active && (px == PX_LAST) && (py == PY_LAST);
    tick_run    = (state == S_WAIT || state == S_SHIFT || state == S_DRAW);
    tick_wrap   = tick_run && (tick_cnt == TICK_LAST);
    new_row     = LANES'(1) << lfsr[LB-1:0];
    lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_OVER: if (start_ok) state_next = S_DRAW;
      S_WAIT: begin
        if (miss_limit)       state_next = S_ODRAW;
        else if (tick_pend)   state_next = S_SHIFT;
        else if (redraw_pend) state_next = S_DRAW;
      end
      S_SHIFT: state_next = miss_limit ? S_ODRAW : S_DRAW;
      // A miss limit reached mid-draw waits for the pass to finish.
      S_DRAW:  if (scan_last) state_next = miss_limit ? S_ODRAW : S_WAIT;
      S_ODRAW: if (scan_last) state_next = S_OVER;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      board       <= '0;
      lfsr        <= SEED;
      tick_cnt    <= '0;
      tick_pend   <= 1'b0;
      redraw_pend <= 1'b0;
      score_q     <= 8'd0;
      misses_q    <= 4'd0;
    end else if (start_ok) begin
      // lfsr deliberately carries over so each game gets a different tile sequence.
      board       <= '0;
      tick_cnt    <= '0;
      tick_pend   <= 1'b0;
      redraw_pend <= 1'b0;
      score_q     <= 8'd0;
      misses_q    <= 4'd0;
    end else begin
      misses_q <= misses_next;

      if (hit_good) begin
        board[ROWS-1] <= board[ROWS-1] & ~bus.hit;
        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
      end

      if (state == S_SHIFT) begin
        board <= {board[ROWS-2:0], new_row};
        lfsr  <= {lfsr[6:0], lfsr_fb};
      end

      if (tick_run) tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);

      if (tick_wrap)              tick_pend <= 1'b1;
      else if (state == S_SHIFT)  tick_pend <= 1'b0;

      // Clearing on entry wins: the pass that starts now already shows the hit.
      if (state != S_DRAW && state_next == S_DRAW) redraw_pend <= 1'b0;
      else if (hit_good)                           redraw_pend <= 1'b1;
    end
  end

  // Counters rest at zero outside a pass and wrap to zero on the last pixel,
  // so DRAW -> ODRAW can chain passes without an extra cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px <= '0; sx <= '0; lane_c <= '0;
      py <= '0; sy <= '0; row_c  <= '0;
    end else if (scan_active && !scan_last) begin
      if (px == PX_LAST) begin
        px     <= '0;
        sx     <= '0;
        lane_c <= '0;
        py     <= py + 9'd1;
        if (sy == SY_LAST) begin
          sy    <= '0;
          row_c <= row_c + RB'(1);
        end else begin
          sy <= sy + 9'd1;
        end
      end else begin
        px <= px + 10'd1;
        if (sx == SX_LAST) begin
          sx     <= '0;
          lane_c <= lane_c + LB'(1);
        end else begin
          sx <= sx + 10'd1;
        end
      end
    end else begin
      px <= '0; sx <= '0; lane_c <= '0;
      py <= '0; sy <= '0; row_c  <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_write_q <= 1'b0;
    end else begin
      vga_write_q <= scan_active;
      if (scan_active) begin
        vga_x_q <= px + 10'(X0);
        vga_y_q <= py + 9'(Y0);
        if (state == S_ODRAW)            vga_color_q <= 3'b100;
        else if (board[row_c][lane_c])   vga_color_q <= 3'b000;
        else                             vga_color_q <= 3'b111;
      end
    end
  end

  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.vga_write = vga_write_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.game_over = (state == S_OVER);
  assign bus.busy      = (state != S_IDLE) && (state != S_OVER);

endmodule

// File: tb/tb_tile_lane_engine.sv
// tb/tb_tile_lane_engine.sv - directed testbench for tile_lane_engine

module tb_tile_lane_engine;

  logic clock;
  logic reset;

  tile_lane_engine_if #(.LANES(4)) bus ();

  tile_lane_engine #(
    .LANES(4), .ROWS(4), .TILE_W(2), .TILE_H(2), .X0(0), .Y0(0),
    .TICK_DIV(200), .MAX_MISS(3), .SEED(8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] cap_x [0:127];
  logic [8:0] cap_y [0:127];
  logic [2:0] cap_c [0:127];

  // Boards packed {row3,row2,row1,row0}, each row one-hot by lane.
  localparam logic [15:0] B_SHIFT1 = 16'h0002;
  localparam logic [15:0] B_SHIFT2 = 16'h0024;
  localparam logic [15:0] B_SHIFT3 = 16'h0242;
  localparam logic [15:0] B_SHIFT4 = 16'h2424;
  localparam logic [15:0] B_HIT    = 16'h0424;
  localparam logic [15:0] B_SHIFT5 = 16'h4241;

  task automatic pulse_start();
    @(negedge clock) bus.start = 1'b1;
    @(negedge clock) bus.start = 1'b0;
  endtask

  task automatic pulse_hit(input logic [3:0] v);
    @(negedge clock) bus.hit = v;
    @(negedge clock) bus.hit = 4'b0000;
  endtask

  // Records one contiguous run of vga_write; n stays 0 if none starts in time.
  task automatic capture_pass(output int n);
    int waitc;
    waitc = 0;
    n = 0;
    @(negedge clock);
    while (bus.vga_write !== 1'b1 && waitc < 1000) begin
      waitc++;
      @(negedge clock);
    end
    while (bus.vga_write === 1'b1 && n < 100) begin
      cap_x[n] = bus.vga_x;
      cap_y[n] = bus.vga_y;
      cap_c[n] = bus.vga_color;
      n++;
      @(negedge clock);
    end
  endtask

  function automatic int pass_errors(input logic [15:0] b, input bit over);
    int errs;
    int x, y;
    logic [2:0] exp_c;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      x = i % 8;
      y = i / 8;
      if (over) exp_c = 3'b100;
      else      exp_c = b[(y / 2) * 4 + (x / 2)] ? 3'b000 : 3'b111;
      if (cap_x[i] !== 10'(x) || cap_y[i] !== 9'(y) || cap_c[i] !== exp_c) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    vectors++;
    if ({bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_write} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%b w=%b, want all 0",
               bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_write);
    end
    vectors++;
    if (bus.score !== 8'd0 || bus.misses !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got score=%0d misses=%0d, want 0/0", bus.score, bus.misses);
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%b game_over=%b, want 0/0", bus.busy, bus.game_over);
    end
  endtask

  task automatic test_first_draw();
    int n, e;
    pulse_start();
    capture_pass(n);
    vectors++;
    if (n !== 64) begin
      miscompares++;
      $display("FAIL first_draw_len: got %0d writes, want 64", n);
    end
    e = pass_errors(16'h0000, 1'b0);
    vectors++;
    if (e !== 0) begin
      miscompares++;
      $display("FAIL first_draw_pixels: got %0d bad pixels, want 0 (all white raster)", e);
    end
    vectors++;
    if (bus.busy !== 1'b1 || bus.vga_write !== 1'b0) begin
      miscompares++;
      $display("FAIL first_draw_wait: got busy=%b w=%b, want 1/0", bus.busy, bus.vga_write);
    end
  endtask

  task automatic test_descent();
    logic [15:0] exp_b [0:3];
    int n, e;
    exp_b[0] = B_SHIFT1;
    exp_b[1] = B_SHIFT2;
    exp_b[2] = B_SHIFT3;
    exp_b[3] = B_SHIFT4;
    for (int k = 0; k < 4; k++) begin
      capture_pass(n);
      e = pass_errors(exp_b[k], 1'b0);
      vectors++;
      if (n !== 64 || e !== 0) begin
        miscompares++;
        $display("FAIL descent_pass%0d: got len=%0d bad=%0d, want len=64 bad=0 board=%h",
                 k + 1, n, e, exp_b[k]);
      end
    end
    vectors++;
    if (bus.misses !== 4'd0) begin
      miscompares++;
      $display("FAIL descent_misses: got %0d, want 0", bus.misses);
    end
  endtask

  task automatic test_hits();
    int n, e;
    pulse_hit(4'b0100);
    vectors++;
    if (bus.misses !== 4'd1 || bus.score !== 8'd0) begin
      miscompares++;
      $display("FAIL wrong_lane: got misses=%0d score=%0d, want 1/0", bus.misses, bus.score);
    end
    pulse_hit(4'b0011);
    vectors++;
    if (bus.misses !== 4'd2 || bus.score !== 8'd0) begin
      miscompares++;
      $display("FAIL multi_lane: got misses=%0d score=%0d, want 2/0", bus.misses, bus.score);
    end
    pulse_hit(4'b0010);
    vectors++;
    if (bus.score !== 8'd1 || bus.misses !== 4'd2) begin
      miscompares++;
      $display("FAIL good_hit: got score=%0d misses=%0d, want 1/2", bus.score, bus.misses);
    end
    capture_pass(n);
    e = pass_errors(B_HIT, 1'b0);
    vectors++;
    if (n !== 64 || e !== 0) begin
      miscompares++;
      $display("FAIL hit_redraw: got len=%0d bad=%0d, want len=64 bad=0", n, e);
    end
  endtask

  task automatic test_game_over();
    int n, e, w;
    capture_pass(n);
    e = pass_errors(B_SHIFT5, 1'b0);
    vectors++;
    if (n !== 64 || e !== 0 || bus.misses !== 4'd2) begin
      miscompares++;
      $display("FAIL shift5_pass: got len=%0d bad=%0d misses=%0d, want 64/0/2", n, e, bus.misses);
    end
    capture_pass(n);
    e = pass_errors(16'h0000, 1'b1);
    vectors++;
    if (n !== 64 || e !== 0) begin
      miscompares++;
      $display("FAIL over_pass: got len=%0d bad=%0d, want len=64 bad=0 (all red)", n, e);
    end
    vectors++;
    if (bus.game_over !== 1'b1 || bus.busy !== 1'b0 || bus.misses !== 4'd3) begin
      miscompares++;
      $display("FAIL over_flags: got go=%b busy=%b misses=%0d, want 1/0/3",
               bus.game_over, bus.busy, bus.misses);
    end
    pulse_hit(4'b0001);
    pulse_hit(4'b0100);
    w = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.vga_write === 1'b1) w++;
    end
    vectors++;
    if (bus.misses !== 4'd3 || bus.score !== 8'd1 || w !== 0) begin
      miscompares++;
      $display("FAIL over_idle: got misses=%0d score=%0d writes=%0d, want 3/1/0",
               bus.misses, bus.score, w);
    end
    pulse_start();
    vectors++;
    if (bus.score !== 8'd0 || bus.misses !== 4'd0 || bus.busy !== 1'b1 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL restart: got score=%0d misses=%0d busy=%b go=%b, want 0/0/1/0",
               bus.score, bus.misses, bus.busy, bus.game_over);
    end
  endtask

  task automatic test_reset_mid_draw();
    int waitc, w;
    waitc = 0;
    while (bus.vga_write !== 1'b1 && waitc < 1000) begin
      waitc++;
      @(negedge clock);
    end
    repeat (29) @(negedge clock);
    vectors++;
    if (bus.vga_write !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_draw_active: got w=%b at draw cycle 30, want 1", bus.vga_write);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_write} !== 23'd0 ||
        bus.score !== 8'd0 || bus.misses !== 4'd0 || bus.busy !== 1'b0 || bus.game_over !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got x=%0d y=%0d c=%b w=%b score=%0d misses=%0d busy=%b go=%b, want all 0",
               bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_write, bus.score, bus.misses,
               bus.busy, bus.game_over);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    w = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clock);
      if (bus.vga_write === 1'b1 || bus.busy === 1'b1) w++;
    end
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %0d active cycles after reset, want 0", w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 4'b0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_first_draw();
    test_descent();
    test_hits();
    test_game_over();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
